hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

Parametrised forwarding and load-use hazard unit for the 5-stage integer pipeline. It sits beside the register file read in s3 and replaces the single-source ALU bypass with multi-source forwarding: s4 ALU result, s5 write-back data and, optionally, a retired-write buffer. The bypass covers NUM_RD read ports. It also detects load-use hazards and holds s3 for a programmable number of cycles through a small stall state machine, and it counts stall cycles for performance monitoring.

## Interface
- DATA_WIDTH, 32, register data width
- REG_WORDS, 32, architectural registers; register 0 is hard-wired zero
- ADDR_LEFT, $clog2(REG_WORDS)-1, MSB of a register address
- NUM_RD, 2, number of s3 read ports
- LOAD_LAT, 1, stall cycles per load-use hazard (legal range 1..7)
- STAT_W, 16, width of the stall counter

Ports:
- clk  in  1  pipeline clock
- rst_  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush; aborts any stall in progress
- r_addr_s3  in  NUM_RD*(ADDR_LEFT+1)  packed read addresses, port 0 in the LSBs
- r_data_s3  in  NUM_RD*DATA_WIDTH  register-file read data, same packing
- rw_s4  in  1  s4 instruction writes a register
- ld_s4  in  1  s4 instruction is a load (result not yet available)
- waddr_s4  in  ADDR_LEFT+1  s4 destination
- alu_out_s4  in  DATA_WIDTH  s4 ALU result
- rw_s5  in  1  s5 writes a register this cycle
- waddr_s5  in  ADDR_LEFT+1  s5 destination
- wdata_s5  in  DATA_WIDTH  s5 write-back data
- fwd_data_s3  out  NUM_RD*DATA_WIDTH  operand data after forwarding
- stall_s3  out  1  hold s3/earlier stages and insert a bubble into s4
- stall_cnt  out  STAT_W  saturating count of stall cycles

## Operation
- Forwarding is combinational and applies per port p, in priority order:
  - s4 wins if rw_s4 && !ld_s4 && waddr_s4!=0 && waddr_s4==addr_p.
  - Otherwise s5 wins if rw_s5 && waddr_s5!=0 && match.
  - Otherwise the retired buffer wins if it is valid and matches (with FWD_WB_BUF_EN only).
  - Otherwise the port takes r_data_s3.
- Address 0 never forwards. fwd_data for address 0 is r_data_s3 unmodified.
- The hazard is hit = rw_s4 && ld_s4 && waddr_s4!=0 && (waddr_s4 matches any port).
- The FSM has two states, IDLE and STALL, and a 3-bit counter cnt.
  - IDLE: stall_s3 = hit. If hit && !flush && LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1. Otherwise stay in IDLE.
  - STALL: stall_s3=1 regardless of s4 inputs, because s4 holds a bubble. cnt decrements each cycle. At cnt==1 return to IDLE.
  - flush in any state: stall_s3=0 that cycle, next state IDLE, cnt=0.
- With LOAD_LAT=1 the stall lasts exactly one cycle. The load then sits in s5 and is forwarded from s5.
- stall_cnt increments on every cycle with stall_s3=1 and saturates at all-ones.

## Timing
- Forwarding latency is 0 cycles, combinational from the s3/s4/s5 inputs.
- A stall lasts exactly LOAD_LAT consecutive cycles from the cycle in which hit is first seen. stall_s3 in the first cycle is combinational from hit.
- Reset values: state=IDLE, cnt=0, stall_cnt=0, retired buffer invalid, stall_s3=0.
- fwd_data_s3 has no reset value; it follows its inputs.
- A reset asserted mid-stall takes effect asynchronously, and stall_s3 drops immediately.
- When flush and hit occur together, flush wins and there is no stall.
- When s4 and s5 target the same register, s4 wins.
- Two ports reading the same register each receive an identical forwarded value.

## Configuration
- FWD_WB_BUF_EN defined:
  - A one-entry register captures {valid, waddr_s5, wdata_s5} on every clk where rw_s5 && waddr_s5!=0. Otherwise valid clears.
  - This register serves as the third forwarding source, for register files without write-then-read bypass.
- FWD_WB_BUF_EN undefined:
  - No buffer is present; only s4 and s5 are forwarding sources.
  - The register file must bypass same-cycle writes.

## Test plan
- s4 ALU write, no load: rw_s4=1, waddr_s4=5, alu_out_s4=0xDEAD_BEEF; port 0 and port 1 both read 5 -> both fwd_data = 0xDEAD_BEEF, stall_s3=0.
- s4/s5 priority: s4 writes 7 with 0x1111, s5 writes 7 with 0x2222 -> fwd = 0x1111. Repeat with rw_s4=0 -> fwd = 0x2222.
- Zero register: rw_s4=1, waddr_s4=0, alu_out=0xFFFF_FFFF, port reads 0 with r_data=0 -> fwd = 0, no stall, even with ld_s4=1.
- Load-use with LOAD_LAT=3: ld_s4=1, waddr_s4=9, port 1 reads 9 -> stall_s3=1 for exactly 3 cycles, then 0; stall_cnt increases by 3.
- Flush mid-stall with LOAD_LAT=3: hit, then flush on cycle 2 -> stall_s3=0 that cycle, IDLE next; stall_cnt=1. Also reset mid-stall -> stall_s3=0 asynchronously, stall_cnt=0.
- With FWD_WB_BUF_EN: s5 writes 12 with 0xCAFE; the next cycle has no s4/s5 match and r_data=stale 0 -> fwd = 0xCAFE. Without the macro -> fwd = 0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Multi-source operand forwarding and load-use stall unit for the s3 register read.
// Optional retired-write buffer as third forwarding source: define FWD_WB_BUF_EN.
module hazard_fwd_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WORDS  = 32,
  parameter int ADDR_LEFT  = $clog2(REG_WORDS) - 1,
  parameter int NUM_RD     = 2,
  parameter int LOAD_LAT   = 1,
  parameter int STAT_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst_,
  input  logic                               flush,
  input  logic [NUM_RD*(ADDR_LEFT+1)-1:0]    r_addr_s3,
  input  logic [NUM_RD*DATA_WIDTH-1:0]       r_data_s3,
  input  logic                               rw_s4,
  input  logic                               ld_s4,
  input  logic [ADDR_LEFT:0]                 waddr_s4,
  input  logic [DATA_WIDTH-1:0]              alu_out_s4,
  input  logic                               rw_s5,
  input  logic [ADDR_LEFT:0]                 waddr_s5,
  input  logic [DATA_WIDTH-1:0]              wdata_s5,
  output logic [NUM_RD*DATA_WIDTH-1:0]       fwd_data_s3,
  output logic                               stall_s3,
  output logic [STAT_W-1:0]                  stall_cnt
);

  localparam int AW = ADDR_LEFT + 1;

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic              w_hit;
  logic [STAT_W-1:0] r_stall_cnt;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

`ifdef FWD_WB_BUF_EN
  logic                  r_buf_vld;
  logic [ADDR_LEFT:0]    r_buf_addr;
  logic [DATA_WIDTH-1:0] r_buf_data;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_buf_vld <= 1'b0;
    else       r_buf_vld <= rw_s5 && (waddr_s5 != '0);
  end

  // Payload needs no reset: it is only consumed while r_buf_vld is set.
  always_ff @(posedge clk) begin
    if (rw_s5 && (waddr_s5 != '0)) begin
      r_buf_addr <= waddr_s5;
      r_buf_data <= wdata_s5;
    end
  end
`endif

  // s3 stage: per-port source selection, youngest producer first
  always_comb begin
    fwd_data_s3 = r_data_s3;
    for (int p = 0; p < NUM_RD; p++) begin
      if (r_addr_s3[p*AW +: AW] != '0) begin
        if (rw_s4 && !ld_s4 && (waddr_s4 == r_addr_s3[p*AW +: AW]))
          fwd_data_s3[p*DATA_WIDTH +: DATA_WIDTH] = alu_out_s4;
        else if (rw_s5 && (waddr_s5 == r_addr_s3[p*AW +: AW]))
          fwd_data_s3[p*DATA_WIDTH +: DATA_WIDTH] = wdata_s5;
`ifdef FWD_WB_BUF_EN
        else if (r_buf_vld && (r_buf_addr == r_addr_s3[p*AW +: AW]))
          fwd_data_s3[p*DATA_WIDTH +: DATA_WIDTH] = r_buf_data;
`endif
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rw_s4 && ld_s4 && (waddr_s4 != '0) && (waddr_s4 == r_addr_s3[p*AW +: AW]))
        w_hit = 1'b1;
    end
  end

  // Reset gates the output so a mid-stall reset drops stall_s3 without waiting for a clock.
  assign stall_s3  = rst_ && !flush && ((r_state == S_STALL) || w_hit);
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit && (LOAD_LAT > 1)) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = 3'(LOAD_LAT - 1);
          end
        end
        S_STALL: begin
          if (r_cnt == 3'd1) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt   = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (stall_s3) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule
